// File: rtl/image_streamer.sv
// rtl/image_streamer.sv - raster readback of the output image onto a valid/ready stream with frame checksum
module image_streamer #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int ADDR_W     = 6,
  parameter int PIX_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  input  logic [PIX_W-1:0]  in_pix,
  output logic              rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_sof,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PIX_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_start_q;
  logic [ADDR_W-1:0]  r_row;
  logic [ADDR_W-1:0]  r_col;
  logic               r_inflight;
  logic               r_infl_sof;
  logic               r_infl_last;
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_checksum;

  logic               w_start_edge;
  logic               w_launch;
  logic               w_push;
  logic               w_pop;
  logic               w_credit_ok;
  logic               w_issue;
  logic               w_at_first;
  logic               w_at_final;
  logic               w_drained;
  logic [CNT_W:0]     w_used;
  logic [CNT_W:0]     w_limit;
  logic [ENT_W-1:0]   w_head;

  assign w_start_edge = start && !r_start_q;
  assign w_launch     = (r_state == S_IDLE) && w_start_edge;
  assign w_push       = r_inflight;
  assign w_pop        = m_valid && m_ready;
  assign w_at_first   = (r_row == '0) && (r_col == '0);
  assign w_at_final   = (r_row == ADDR_W'(IMG_H - 1)) && (r_col == ADDR_W'(IMG_W - 1));

  // Credit: buffered + in-flight entries must stay below depth, counting a pop this cycle as freed space.
  assign w_used      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_limit     = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, w_pop};
  assign w_credit_ok = w_used < w_limit;

  // Frame is finished once nothing is in flight and the buffer empties this cycle at the latest.
  assign w_drained = !r_inflight && ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop));

  // State register and start-edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_start_q <= start;
    end
  end

  // Next-state and control outputs; read issue is gated by FIFO credit.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) w_next_state = S_READ;
      end
      S_READ: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_at_final) w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drained) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign rd_en = w_issue;
  assign row   = r_row;
  assign col   = r_col;

  // Raster address counter: advances only on an issued read, restarts at (0,0) on launch.
  always_ff @(posedge clk) begin
    if (rst || w_launch) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_issue) begin
      if (r_col == ADDR_W'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (r_row == ADDR_W'(IMG_H - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Track the read in flight together with its frame-position tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight  <= 1'b0;
      r_infl_sof  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_inflight  <= w_issue;
      r_infl_sof  <= w_issue && w_at_first;
      r_infl_last <= w_issue && w_at_final;
    end
  end

  // FIFO storage, written with the returned pixel and its tags.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_infl_last, r_infl_sof, in_pix};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign m_valid = (r_count != '0);
  assign m_data  = m_valid ? w_head[PIX_W-1:0] : '0;
  assign m_sof   = m_valid && w_head[PIX_W];
  assign m_last  = m_valid && w_head[PIX_W+1];

  // Frame checksum: cleared on launch, accumulates every accepted beat.
  always_ff @(posedge clk) begin
    if (rst || w_launch) r_checksum <= '0;
    else if (w_pop)      r_checksum <= r_checksum + {{(32 - PIX_W){1'b0}}, m_data};
  end

  assign checksum = r_checksum;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_image_streamer.sv
// tb/tb_image_streamer.sv - randomized self-checking bench for image_streamer against a raster reference model
module tb_image_streamer;

  localparam int NPIX = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  row;
  logic [5:0]  col;
  logic [23:0] in_pix;
  logic        rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  // 0: pattern image, 1: constant white image
  int mem_mode   = 0;
  // 0: always ready, 1: random 50%, 2: never ready
  int ready_mode = 0;
  logic tb_clear = 1'b0;

  int          k;
  int          done_cnt;
  int          rd_cnt;
  logic [31:0] exp_sum;

  image_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row      (row),
    .col      (col),
    .in_pix   (in_pix),
    .rd_en    (rd_en),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sof    (m_sof),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix_of(input int r, input int c);
    if (mem_mode == 1) return 24'hFFFFFF;
    return 24'((r << 16) | (c << 8) | (r ^ c));
  endfunction

  function automatic logic [23:0] model_pix(input int idx);
    return pix_of(idx / 64, idx % 64);
  endfunction

  // Image memory: one-cycle read latency, garbage when not strobed.
  always @(posedge clk) begin
    if (rd_en) in_pix <= pix_of(int'(row), int'(col));
    else       in_pix <= 24'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic clear_model();
    tb_clear = 1'b1;
    tick();
    tb_clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      tick();
      cyc++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_beats(input int n);
    int guard = 0;
    while (k < n && guard < 20000) begin
      tick();
      guard++;
    end
    chk("beat_wait_timeout", 32'(k >= n), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_row"}, 32'(row), 32'd0);
    chk({tag, "_col"}, 32'(col), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_m_sof"}, 32'(m_sof), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask

  // Per-cycle comparison of the stream against the raster model.
  task automatic compare_loop();
    logic        stalled = 1'b0;
    logic [23:0] p_data = '0;
    logic        p_sof = 1'b0;
    logic        p_last = 1'b0;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst || tb_clear) begin
        k = 0; exp_sum = 0; done_cnt = 0; rd_cnt = 0; stalled = 1'b0;
      end else begin
        if (rd_en) rd_cnt++;
        if (stalled) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== p_data || m_sof !== p_sof || m_last !== p_last) begin
            errors++;
            $display("FAIL stall_hold: got v=%b d=%h s=%b l=%b expected v=1 d=%h s=%b l=%b",
                     m_valid, m_data, m_sof, m_last, p_data, p_sof, p_last);
          end
        end
        if (m_valid && m_ready) begin
          e = model_pix(k);
          checks++;
          if (k >= NPIX || m_data !== e || m_sof !== (k == 0) || m_last !== (k == NPIX - 1)) begin
            errors++;
            $display("FAIL raster_beat %0d: got d=%h s=%b l=%b expected d=%h s=%b l=%b",
                     k, m_data, m_sof, m_last, e, (k == 0), (k == NPIX - 1));
          end
          if (k == NPIX - 1 && mem_mode == 0) chk("last_beat_literal", 32'(m_data), 32'h003F3F00);
          exp_sum += {8'b0, e};
          k++;
        end
        stalled = m_valid && !m_ready;
        p_data  = m_data;
        p_sof   = m_sof;
        p_last  = m_last;
        if (done) begin
          done_cnt++;
          chk("done_beat_count", 32'(k), 32'(NPIX));
          chk("done_checksum", checksum, exp_sum);
        end
      end
    end
  endtask

  task automatic run_tests();
    int cyc;
    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Directed latency frame with m_ready high.
    mem_mode = 0; ready_mode = 0;
    clear_model();
    pulse_start();
    chk("t1_busy_T1", 32'(busy), 32'd1);
    chk("t1_rd_en_T1", 32'(rd_en), 32'd1);
    chk("t1_addr_T1", {20'd0, row, col}, 32'd0);
    chk("t1_no_valid_T1", 32'(m_valid), 32'd0);
    tick();
    chk("t1_no_valid_T2", 32'(m_valid), 32'd0);
    tick();
    chk("t1_valid_T3", 32'(m_valid), 32'd1);
    chk("t1_sof_T3", 32'(m_sof), 32'd1);
    chk("t1_data_T3", 32'(m_data), 32'd0);
    wait_done("t1_done_timeout", cyc);
    chk("t1_done_cycle", 32'(3 + cyc), 32'd4099);
    chk("t1_busy_at_done", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_done_once", 32'(done_cnt), 32'd1);

    // Random backpressure.
    ready_mode = 1;
    clear_model();
    pulse_start();
    wait_done("t2_done_timeout", cyc);
    tick();
    chk("t2_beats", 32'(k), 32'(NPIX));
    chk("t2_done_once", 32'(done_cnt), 32'd1);

    // Full backpressure then release.
    ready_mode = 2;
    clear_model();
    pulse_start();
    repeat (100) tick();
    chk("t3_rd_pulses", 32'(rd_cnt), 32'd4);
    chk("t3_row", 32'(row), 32'd0);
    chk("t3_col", 32'(col), 32'd4);
    chk("t3_valid", 32'(m_valid), 32'd1);
    chk("t3_data", 32'(m_data), 32'd0);
    ready_mode = 0;
    wait_done("t3_done_timeout", cyc);
    tick();
    chk("t3_beats", 32'(k), 32'(NPIX));

    // Constant image, start level held high.
    mem_mode = 1; ready_mode = 1;
    clear_model();
    start = 1'b1;
    repeat (10000) tick();
    start = 1'b0;
    tick();
    chk("t4_done_once", 32'(done_cnt), 32'd1);
    chk("t4_beats", 32'(k), 32'(NPIX));
    chk("t4_reads", 32'(rd_cnt), 32'(NPIX));
    chk("t4_checksum_literal", checksum, 32'hFFFFF000);

    // Reset mid-frame, then restart.
    mem_mode = 0; ready_mode = 1;
    clear_model();
    pulse_start();
    wait_beats(1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("t5_after_rst");
    repeat (20) tick();
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    pulse_start();
    wait_done("t5_done_timeout", cyc);
    tick();
    chk("t5_beats", 32'(k), 32'(NPIX));

    // Start edge while busy is ignored.
    clear_model();
    pulse_start();
    wait_beats(2000);
    pulse_start();
    wait_done("t6_done_timeout", cyc);
    repeat (50) tick();
    chk("t6_beats", 32'(k), 32'(NPIX));
    chk("t6_done_once", 32'(done_cnt), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    fork
      compare_loop();
      run_tests();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
Downstream stage of the pixel processing block. After processing signals completion, this block scans the 64x64 output image in raster order through the same row/col addressing scheme. It streams every pixel out on a valid/ready interface, using a small FIFO to absorb backpressure, and computes a frame checksum. It is the readback path from the output image memory to the host/bench.

Parameters:
IMG_W, 64, pixels per row (columns)
IMG_H, 64, rows per frame
ADDR_W, 6, width of row/col address
PIX_W, 24, pixel width (R 23:16, G 15:8, B 7:0)
FIFO_DEPTH, 4, output buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  frame request; rising-edge detected, level-tolerant (may be driven by filter_done held high)
row  out  ADDR_W  read row address into output image memory
col  out  ADDR_W  read column address into output image memory
in_pix  in  PIX_W  read data; valid exactly 1 cycle after row/col presented with rd_en=1
rd_en  out  1  read strobe for the addressed pixel
m_valid  out  1  stream data valid
m_ready  in  1  downstream accepts beat when m_valid&&m_ready
m_data  out  PIX_W  pixel value
m_sof  out  1  high with beat for pixel (0,0)
m_last  out  1  high with beat for pixel (IMG_H-1, IMG_W-1)
busy  out  1  high from start edge until done pulse
done  out  1  one-cycle pulse after final beat accepted
checksum  out  32  sum of all accepted m_data (zero-extended), mod 2^32; valid when done=1, held until next start

Behaviour:
- Reset (sync): state=IDLE; row, col, rd_en, m_valid, m_data, m_sof, m_last, busy, done, checksum, FIFO count, in-flight flag, start-edge register all 0. Reset wins over every other event, including mid-frame; the partial frame is discarded and no done is issued.
- Start detect: start_q registered each cycle. A rising edge (start && !start_q) in IDLE launches a frame. Edges while busy are ignored. A level held high after the frame does not retrigger.
- FSM:
  - IDLE: busy=0. On start edge: clear checksum, row=col=0, go to READ.
  - READ: issue rd_en=1 for (row,col) when credit allows, where credit = FIFO_DEPTH - count - inflight + pop_this_cycle > 0. After each issue, col increments; col wrap IMG_W-1 -> 0 increments row. After issuing (IMG_H-1, IMG_W-1), go to DRAIN. row/col must not advance when no read is issued.
  - DRAIN: no reads; stay until FIFO empty and no read in flight, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy falls the same cycle, go to IDLE.
- Read capture: data sampled from in_pix the cycle after rd_en and pushed into the FIFO, with sof/last tags computed from the issued address.
- Stream: m_valid = FIFO non-empty. m_data/m_sof/m_last come from the FIFO head (registered). While m_valid && !m_ready, all stream outputs hold stable. Pop on handshake. Push and pop in the same cycle are legal; count is unchanged.
- Overflow is impossible by the credit rule. Any push while full is a design error and must be covered by an assertion.
- Checksum: checksum <= checksum + {8'b0, m_data} on every handshake. Wrap-around mod 2^32 is silent.
- Latency: start edge sampled at cycle T -> rd_en for (0,0) at T+1 -> FIFO push at T+2 -> m_valid at T+3. With m_ready tied high, one beat per cycle: last beat at T+3+4095, done at T+3+4096.
- Exactly IMG_W*IMG_H beats per frame, in raster order (row-major, col fastest), with no duplicates or drops.

Test Plan:
- Memory model pix=(row<<16)|(col<<8)|(row^col), m_ready=1, start pulse at T -> first m_valid at T+3 with m_sof=1 and m_data=0x000000; 4096 consecutive beats; last beat m_data=0x3F3F00 with m_last=1; done at T+4099; busy high T+1..T+4099.
- Same image, m_ready random 50% -> 4096 beats in exact raster order; m_data/m_sof/m_last unchanged across every stalled cycle; checksum matches the bench sum.
- m_ready=0 for 100 cycles after start -> exactly 4 rd_en pulses issued, then row=0 and col=4 frozen; m_valid high holding 0x000000. On releasing m_ready, streaming resumes with no gap in the sequence.
- Constant pixel 0xFFFFFF, start held high for 10000 cycles -> exactly one frame, checksum=0xFFFFF000, a single done pulse, no second frame.
- rst asserted for 1 cycle at beat 1000 -> next cycle all outputs 0 and no done. A new start edge restarts from (0,0) with m_sof=1 and a fresh checksum.
- Start edge while busy (mid-READ) -> ignored: beat count stays 4096 and exactly one done.
